// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch-stage program-counter sequencer.
package fetch_pkg;

  localparam int INSTR_W    = 32;
  localparam int PC_W       = 32;
  localparam int WORD_SHIFT = 2;

  localparam logic [PC_W-1:0] PC_STEP          = 32'd4;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int              DEFAULT_MEM_WORDS = 128;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT,
    FAULT
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, instruction memory, control and decode.
interface fetch_sequencer_if;
  import fetch_pkg::*;

  logic [PC_W-1:0]    mem_addr;
  logic [INSTR_W-1:0] mem_data;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               halt_req;
  logic               id_ready;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic [PC_W-1:0]    if_npc;
  logic               halted;
  logic               fault;
  logic [31:0]        fetch_count;

  modport master (
    output mem_addr, if_valid, if_instr, if_pc, if_npc, halted, fault, fetch_count,
    input  mem_data, redirect_valid, redirect_pc, halt_req, id_ready
  );

  modport slave (
    input  mem_addr, if_valid, if_instr, if_pc, if_npc, halted, fault, fetch_count,
    output mem_data, redirect_valid, redirect_pc, halt_req, id_ready
  );

endinterface

// File: rtl/fetch_sequencer_pc_gen.sv
// Combinational next-pc selection, fetch-address legality check and word-address formation.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int MEM_WORDS = DEFAULT_MEM_WORDS
) (
  input  logic [PC_W-1:0] pc_q,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            advance,
  output logic [PC_W-1:0] pc_d,
  output logic            pc_ok,
  output logic [PC_W-1:0] mem_addr
);

  localparam logic [PC_W-1:0] MEM_LIMIT = PC_W'(MEM_WORDS);

  // The range test runs on the word index before any +4, so a pc near the top wraps only after it has already faulted.
  assign mem_addr = {{WORD_SHIFT{1'b0}}, pc_q[PC_W-1:WORD_SHIFT]};
  assign pc_ok    = (pc_q[WORD_SHIFT-1:0] == '0) && (mem_addr < MEM_LIMIT);
  assign pc_d     = redirect ? redirect_pc : (advance ? pc_q + PC_STEP : pc_q);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: FSM, pc register, IF/ID slot with valid/ready handoff and handoff counter.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              MEM_WORDS = DEFAULT_MEM_WORDS
) (
  input logic               clk,
  input logic               rst_n,
  fetch_sequencer_if.master bus
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;
  logic [PC_W-1:0]    if_npc_q, if_npc_d;
  logic [31:0]        fetch_count_q, fetch_count_d;
  logic               pc_ok;
  logic               advance;
  logic               redirect_take;
  logic               consumed;
  logic               load;

  fetch_pc_gen #(.MEM_WORDS(MEM_WORDS)) u_pc_gen (
    .pc_q        (pc_q),
    .redirect    (redirect_take),
    .redirect_pc (bus.redirect_pc),
    .advance     (advance),
    .pc_d        (pc_d),
    .pc_ok       (pc_ok),
    .mem_addr    (bus.mem_addr)
  );

  always_comb begin
    state_d       = state_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_npc_d      = if_npc_q;
    advance       = 1'b0;
    consumed      = if_valid_q && bus.id_ready;
    load          = !if_valid_q || bus.id_ready;
    redirect_take = bus.redirect_valid && (state_q != IDLE);
    fetch_count_d = fetch_count_q + 32'(consumed);

    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (load && pc_ok) begin
          if_valid_d = 1'b1;
          if_instr_d = bus.mem_data;
          if_pc_d    = pc_q;
          if_npc_d   = pc_q + PC_STEP;
          advance    = 1'b1;
          if (bus.halt_req) state_d = HALT;
        end else if (load) begin
          state_d = FAULT;
          if (consumed) if_valid_d = 1'b0;
        end else if (bus.halt_req) begin
          state_d = HALT;
        end
      end
      default: begin
        if (consumed) if_valid_d = 1'b0;
      end
    endcase

    // A redirect flushes the slot and suppresses any load decided above.
    if (redirect_take) begin
      advance    = 1'b0;
      if_valid_d = 1'b0;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
      if_npc_d   = if_npc_q;
      state_d    = bus.halt_req ? HALT : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      if_npc_q      <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_npc_q      <= if_npc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.if_valid    = if_valid_q;
  assign bus.if_instr    = if_instr_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_npc      = if_npc_q;
  assign bus.halted      = (state_q == HALT);
  assign bus.fault       = (state_q == FAULT);
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a combinational instruction-memory model.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] image [128];

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .MEM_WORDS(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_data = (bus.mem_addr < 32'd128) ? image[bus.mem_addr[6:0]] : 32'hDEAD_BEEF;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic rv, input logic [31:0] rpc,
                                input logic halt, input logic ready);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.halt_req       = halt;
    bus.id_ready       = ready;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic valid, input logic [31:0] addr,
                              input logic [31:0] count, input logic hlt, input logic flt);
    check_output({tag, "_valid"},  32'(bus.if_valid), 32'(valid));
    check_output({tag, "_addr"},   bus.mem_addr,      addr);
    check_output({tag, "_count"},  bus.fetch_count,   count);
    check_output({tag, "_halted"}, 32'(bus.halted),   32'(hlt));
    check_output({tag, "_fault"},  32'(bus.fault),    32'(flt));
  endtask

  task automatic check_slot(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    check_output({tag, "_valid"}, 32'(bus.if_valid), 32'd1);
    check_output({tag, "_pc"},    bus.if_pc,         pc);
    check_output({tag, "_instr"}, bus.if_instr,      instr);
    check_output({tag, "_npc"},   bus.if_npc,        pc + 32'd4);
  endtask

  task automatic check_reset_values(input string tag);
    check_status(tag, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_output({tag, "_pc"},    bus.if_pc,    32'h0);
    check_output({tag, "_instr"}, bus.if_instr, 32'h0);
    check_output({tag, "_npc"},   bus.if_npc,   32'h0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) image[i] = {16'hC0DE, 16'(i)};
    image[0] = 32'h0023_00AA;
    image[1] = 32'h1065_4321;
    image[2] = 32'h0010_0022;
    image[3] = 32'h8C12_3456;
    image[8] = 32'h1201_2345;

    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    repeat (2) tick();
    check_reset_values("reset");

    // Straight-line fetch after reset, one idle cycle first.
    rst_n = 1'b1;
    tick();
    check_status("t1_idle", 1'b0, 32'h0, 32'd0, 1'b0, 1'b0);
    tick();
    check_slot("t1_w0", 32'h0, 32'h0023_00AA);
    check_status("t1_w0", 1'b1, 32'h1, 32'd0, 1'b0, 1'b0);
    tick();
    check_slot("t1_w1", 32'h4, 32'h1065_4321);
    check_status("t1_w1", 1'b1, 32'h2, 32'd1, 1'b0, 1'b0);

    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_slot("t2_stall", 32'h4, 32'h1065_4321);
      check_status("t2_stall", 1'b1, 32'h2, 32'd1, 1'b0, 1'b0);
    end
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    check_slot("t2_resume", 32'h8, 32'h0010_0022);
    check_status("t2_resume", 1'b1, 32'h3, 32'd2, 1'b0, 1'b0);

    apply_stimulus(1'b1, 32'h20, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
    check_status("t3_flush", 1'b0, 32'h8, 32'd3, 1'b0, 1'b0);
    tick();
    check_slot("t3_target", 32'h20, 32'h1201_2345);
    check_status("t3_target", 1'b1, 32'h9, 32'd3, 1'b0, 1'b0);

    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
    check_slot("t4_last", 32'h24, 32'hC0DE_0009);
    check_status("t4_last", 1'b1, 32'hA, 32'd4, 1'b1, 1'b0);
    tick();
    check_status("t4_drain", 1'b0, 32'hA, 32'd5, 1'b1, 1'b0);
    tick();
    check_status("t4_hold", 1'b0, 32'hA, 32'd5, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'h0C, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
    check_status("t4_resume", 1'b0, 32'h3, 32'd5, 1'b0, 1'b0);
    tick();
    check_slot("t4_w3", 32'hC, 32'h8C12_3456);
    check_status("t4_w3", 1'b1, 32'h4, 32'd5, 1'b0, 1'b0);

    // Reset dropped between edges must clear everything before the next rising edge.
    #2 rst_n = 1'b0;
    #1 check_reset_values("t6_async");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_status("t6_idle", 1'b0, 32'h0, 32'd0, 1'b0, 1'b0);
    tick();
    check_slot("t6_w0", 32'h0, 32'h0023_00AA);
    tick();
    check_slot("t6_w1", 32'h4, 32'h1065_4321);
    check_status("t6_w1", 1'b1, 32'h2, 32'd1, 1'b0, 1'b0);

    apply_stimulus(1'b1, 32'h202, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
    check_status("t5_misal_rd", 1'b0, 32'h80, 32'd2, 1'b0, 1'b0);
    tick();
    check_status("t5_misal", 1'b0, 32'h80, 32'd2, 1'b0, 1'b1);
    tick();
    check_status("t5_misal_hold", 1'b0, 32'h80, 32'd2, 1'b0, 1'b1);
    apply_stimulus(1'b1, 32'h200, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
    check_status("t5_range_rd", 1'b0, 32'h80, 32'd2, 1'b0, 1'b0);
    tick();
    check_status("t5_range", 1'b0, 32'h80, 32'd2, 1'b0, 1'b1);
    apply_stimulus(1'b1, 32'h4, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
    check_status("t5_recover", 1'b0, 32'h1, 32'd2, 1'b0, 1'b0);
    tick();
    check_slot("t5_w1", 32'h4, 32'h1065_4321);
    check_status("t5_w1", 1'b1, 32'h2, 32'd2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter sequencer for the fetch stage.
- Drives the word address of the combinational instruction memory and captures the returned word into the IF/ID register.
- Presents that register to decode through a valid/ready handshake.
- Handles branch/jump redirects, halt requests, address faults and decode backpressure.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset
MEM_WORDS, 128, instruction memory depth in 32-bit words; word indices >= MEM_WORDS fault

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
mem_addr  output  32  word index to instruction memory, = {2'b00, pc[31:2]}, combinational from pc register
mem_data  input  32  instruction word, valid same cycle as mem_addr
redirect_valid  input  1  load new PC (branch/jump/resume)
redirect_pc  input  32  target byte address
halt_req  input  1  stop fetching after current slot
id_ready  input  1  decode accepts if_* this cycle
if_valid  output  1  IF/ID slot holds an instruction
if_instr  output  32  fetched instruction
if_pc  output  32  byte address of if_instr
if_npc  output  32  if_pc + 4
halted  output  1  in HALT state
fault  output  1  in FAULT state
fetch_count  output  32  count of accepted handoffs (if_valid && id_ready)

Behaviour:
- Async reset (rst_n low), effective immediately:
  - pc=RESET_PC, state=IDLE.
  - if_valid=0, if_instr=0, if_pc=0, if_npc=0.
  - halted=0, fault=0, fetch_count=0.
- States: IDLE, RUN, HALT, FAULT.
- IDLE: one cycle, no fetch, then RUN unconditionally.
- RUN, load condition: load = !if_valid || id_ready.
- RUN, load with pc legal (pc[1:0]==0 and pc[31:2] < MEM_WORDS):
  - if_instr<=mem_data, if_pc<=pc, if_npc<=pc+4, if_valid<=1, pc<=pc+4.
  - Latency 1 cycle from pc to if_* outputs.
  - Sustained 1 instruction/cycle when id_ready=1.
- RUN, load with pc illegal:
  - FAULT; if_valid<=0 if the slot was consumed, else held; pc held.
- RUN, !load (if_valid && !id_ready): pc and all if_* held stable.
- fetch_count increments on every edge where if_valid && id_ready, in any state; wraps mod 2^32.
- redirect_valid (any state except IDLE) has top priority:
  - pc<=redirect_pc, if_valid<=0 (flush), no load that edge.
  - State becomes RUN, or HALT if halt_req is also asserted.
  - halted and fault are cleared accordingly.
  - Redirect sampled at edge E: if_pc=redirect_pc valid after edge E+1.
- halt_req in RUN without redirect:
  - HALT on that edge; a load qualified that same edge still happens.
  - halted=1.
- HALT:
  - No loads; the existing if_valid is held until consumed, then cleared.
  - Exit only via redirect or reset.
- FAULT:
  - fault=1, no loads; the slot drains as in HALT.
  - Exit via redirect (the legality check reapplies at next fetch) or reset.
- pc+4 arithmetic is mod 2^32. The range check catches overflow before wrap.
- Reset asserted mid-handshake drops if_valid immediately; decode must tolerate this.

Decomposition:
- Package fetch_pkg:
  - state enum {IDLE, RUN, HALT, FAULT}
  - INSTR_W=32, PC_W=32, WORD_SHIFT=2
  - default RESET_PC
- One natural sub-module, fetch_pc_gen (combinational):
  - next-pc mux (redirect / pc+4 / hold)
  - legality check producing pc_ok
  - mem_addr formation
- The top holds the FSM, pc register, IF/ID register and counter.

Test Plan:
1. Image word0=002300AA, word1=10654321, word2=00100022; release rst_n, id_ready=1.
   - IDLE one cycle, then mem_addr 0,1,2.
   - if_pc 0,4,8 with matching instrs on consecutive cycles, if_npc=if_pc+4.
   - fetch_count 1,2,3.
2. While if_pc=4 valid, hold id_ready=0 for 3 cycles.
   - if_instr=10654321, if_pc=4, mem_addr=2 and fetch_count held.
   - Raise id_ready: if_pc=8 next cycle.
3. Redirect to 32'h20 with if_valid=1.
   - Next cycle if_valid=0.
   - Following cycle if_pc=20, if_instr=word8 (12012345).
4. Assert halt_req one cycle.
   - halted=1; after the slot drains, if_valid stays 0.
   - Redirect 32'h0C: halted=0, then if_instr=word3 (8C123456).
5. Redirect 32'h202 (misaligned): fault=1, if_valid=0, no fetch.
   - Redirect 32'h200 (word 128 ≥ MEM_WORDS): fault again.
   - Redirect 32'h4: fault=0, if_instr=word1.
6. Drop rst_n mid-cycle while if_valid=1 and fetch_count=5.
   - All outputs go to reset values before the next clk edge.
   - On release, pc=RESET_PC and the sequence restarts as in test 1.
